// File: rtl/bt_exmem_resp.sv
// BR/EDR external-memory responder: arbitrates bredr_em and pcm_dma onto one SRAM.
// Optional BT_EXMEM_PCM_PRIO_EN: pcm_dma wins every tie instead of round-robin.
`timescale 1ns/1ps
module bt_exmem_resp #(
    parameter int RAM_AW   = 12,
    parameter int WAIT_CYC = 0
) (
    input  logic              bsb_clk,
    input  logic              bsb_rst,
    input  logic [22:0]       bt_exmem_baseadr,
    input  logic              bredr_em_req,
    input  logic [3:0]        bredr_em_we,
    input  logic [22:0]       bredr_em_adr,
    input  logic [31:0]       bredr_em_wdat,
    output logic [31:0]       bredr_em_rdat,
    output logic              bredr_em_ack,
    input  logic              pcm_dma_req,
    input  logic [3:0]        pcm_dma_we,
    input  logic [22:0]       pcm_dma_adr,
    input  logic [31:0]       pcm_dma_wdat,
    output logic [31:0]       pcm_dma_rdat,
    output logic              pcm_dma_ack,
    output logic              ram_cs,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_adr,
    output logic [31:0]       ram_wdat,
    input  logic [31:0]       ram_rdat,
    output logic              exmem_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_CAP,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nx;

    logic              gnt_pcm;
    logic              pick_pcm;
    logic [3:0]        we_q;
    logic [RAM_AW-1:0] adr_q;
    logic [31:0]       wdat_q;
    logic              win_q;
    logic [3:0]        wcnt;
    logic [31:0]       bredr_rdat_q;
    logic [31:0]       pcm_rdat_q;
    logic [3:0]        sel_we;
    logic [22:0]       sel_adr;
    logic [31:0]       sel_wdat;
    logic [22:0]       off;
    logic [20:0]       off_w;
    logic              sel_win;
    logic              any_req;
    logic              unused_ok;

`ifdef BT_EXMEM_PCM_PRIO_EN
    assign pick_pcm = pcm_dma_req;
`else
    logic last_pcm;
    assign pick_pcm = pcm_dma_req & (~bredr_em_req | ~last_pcm);
`endif

    assign any_req = bredr_em_req | pcm_dma_req;

    // Winner's request fields and its offset into the window
    always_comb begin
        sel_we   = pick_pcm ? pcm_dma_we   : bredr_em_we;
        sel_adr  = pick_pcm ? pcm_dma_adr  : bredr_em_adr;
        sel_wdat = pick_pcm ? pcm_dma_wdat : bredr_em_wdat;
        off      = {sel_adr[22:2], 2'b00} - bt_exmem_baseadr;
        off_w    = off[22:2];
        sel_win  = (off_w >> RAM_AW) == '0;
    end

    assign unused_ok = ^{off[1:0], sel_adr[1:0]};

    // State register
    always_ff @(posedge bsb_clk) begin
        if (bsb_rst) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Request latch, wait counter, read-data capture and grant history
    always_ff @(posedge bsb_clk) begin
        if (bsb_rst) begin
            gnt_pcm      <= 1'b0;
            we_q         <= '0;
            adr_q        <= '0;
            wdat_q       <= '0;
            win_q        <= 1'b0;
            wcnt         <= '0;
            bredr_rdat_q <= '0;
            pcm_rdat_q   <= '0;
`ifndef BT_EXMEM_PCM_PRIO_EN
            last_pcm     <= 1'b1;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_pcm <= pick_pcm;
                        we_q    <= sel_we;
                        adr_q   <= off[RAM_AW+1:2];
                        wdat_q  <= sel_wdat;
                        win_q   <= sel_win;
                    end
                end
                S_CAP: begin
                    wcnt <= '0;
                    if (gnt_pcm)
                        pcm_rdat_q <= (win_q && we_q == 4'd0) ? ram_rdat : 32'd0;
                    else
                        bredr_rdat_q <= (win_q && we_q == 4'd0) ? ram_rdat : 32'd0;
                end
                S_WAIT: wcnt <= wcnt + 4'd1;
                S_RESP: begin
`ifndef BT_EXMEM_PCM_PRIO_EN
                    last_pcm <= gnt_pcm;
`endif
                end
                default: ;
            endcase
        end
    end

    // Next state and SRAM / handshake outputs
    always_comb begin
        state_nx     = state;
        ram_cs       = 1'b0;
        ram_we       = '0;
        ram_adr      = '0;
        ram_wdat     = '0;
        bredr_em_ack = 1'b0;
        pcm_dma_ack  = 1'b0;
        exmem_err    = 1'b0;
        unique case (state)
            S_IDLE: if (any_req) state_nx = S_ACC;
            S_ACC: begin
                ram_cs = win_q;
                if (win_q) begin
                    ram_we   = we_q;
                    ram_adr  = adr_q;
                    ram_wdat = wdat_q;
                end
                state_nx = S_CAP;
            end
            S_CAP: state_nx = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (wcnt == 4'(WAIT_CYC - 1)) state_nx = S_RESP;
            S_RESP: begin
                bredr_em_ack = ~gnt_pcm;
                pcm_dma_ack  = gnt_pcm;
                exmem_err    = ~win_q;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bredr_em_rdat = bredr_rdat_q;
    assign pcm_dma_rdat  = pcm_rdat_q;

endmodule
